// File: rtl/rom_load_sequencer.sv
// Purpose: route HPS download bytes to one of four ROM regions, gate core reset, validate the load.
// Latency: a byte accepted at cycle n is presented on WR_* at n+1; DONE rises SETTLE_CYC cycles after drain.
// Backpressure: one-entry buffer held while TGT_RDY=0; a strobe into a full buffer is dropped (OVF, ERR).
// Build option: define ROMLOAD_CKSUM_EN to build the additive download checksum on CKSUM.
module rom_load_sequencer #(
    parameter logic [24:0] B1         = 25'h04000,
    parameter logic [24:0] B2         = 25'h06000,
    parameter logic [24:0] B3         = 25'h07000,
    parameter logic [24:0] TOTAL      = 25'h0A000,
    parameter int          SETTLE_CYC = 64
) (
    input  logic        MCLK,
    input  logic        RST_N,
    input  logic        DLOAD,
    input  logic        ROMEN,
    input  logic [24:0] ROMAD,
    input  logic [7:0]  ROMDT,
    input  logic        TGT_RDY,
    output logic [3:0]  WR_SEL,
    output logic [15:0] WR_AD,
    output logic [7:0]  WR_DT,
    output logic        WR_EN,
    output logic        CORE_RST,
    output logic        DONE,
    output logic        ERR,
    output logic        OVF,
    output logic [15:0] CKSUM
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic          wr_en_q, wr_en_d;
    logic [3:0]    wr_sel_q, wr_sel_d;
    logic [15:0]   wr_ad_q, wr_ad_d;
    logic [7:0]    wr_dt_q, wr_dt_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [24:0]   byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;

    logic          xfer;
    logic          in_range;
    logic          accept;
    logic          load_entry;
    logic [3:0]    dec_sel;
    logic [24:0]   dec_base;
    logic [24:0]   addr_off;

    assign xfer     = wr_en_q & TGT_RDY;
    assign in_range = (ROMAD < TOTAL);
    // A byte fits if the buffer is empty or is being emptied in this same cycle.
    assign accept   = (state_q == S_LOAD) & ROMEN & in_range & (~wr_en_q | TGT_RDY);

    // Region decode: select line and base address for the incoming byte.
    always_comb begin
        dec_sel  = 4'b1000;
        dec_base = B3;
        if (ROMAD < B1) begin
            dec_sel  = 4'b0001;
            dec_base = 25'h0;
        end else if (ROMAD < B2) begin
            dec_sel  = 4'b0010;
            dec_base = B1;
        end else if (ROMAD < B3) begin
            dec_sel  = 4'b0100;
            dec_base = B2;
        end
    end

    assign addr_off = ROMAD - dec_base;

    // Next-state logic: load phases, buffer, counters and sticky flags.
    always_comb begin
        state_d      = state_q;
        wr_en_d      = wr_en_q;
        wr_sel_d     = wr_sel_q;
        wr_ad_d      = wr_ad_q;
        wr_dt_d      = wr_dt_q;
        err_d        = err_q;
        ovf_d        = ovf_q;
        byte_cnt_d   = byte_cnt_q;
        settle_cnt_d = '0;

        case (state_q)
            S_IDLE: begin
                if (DLOAD) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!DLOAD) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (DLOAD) begin
                    state_d = S_LOAD;
                end else if (!wr_en_q) begin
                    if ((byte_cnt_q == TOTAL) && !err_q) begin
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_SETTLE: begin
                if (DLOAD) begin
                    state_d = S_LOAD;
                end else if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
                    state_d = S_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (DLOAD) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase

        // Completed transfer empties the buffer unless refilled below.
        if (xfer) wr_en_d = 1'b0;

        if (accept) begin
            wr_en_d    = 1'b1;
            wr_sel_d   = dec_sel;
            wr_ad_d    = addr_off[15:0];
            wr_dt_d    = ROMDT;
            byte_cnt_d = byte_cnt_q + 1'b1;
        end else if ((state_q == S_LOAD) && ROMEN) begin
            // Dropped byte: out of range, or buffer still full.
            err_d = 1'b1;
            if (in_range) ovf_d = 1'b1;
        end

        // A fresh load discards any pending write and all load status.
        load_entry = (state_d == S_LOAD) && (state_q != S_LOAD);
        if (load_entry) begin
            wr_en_d    = 1'b0;
            wr_sel_d   = '0;
            wr_ad_d    = '0;
            wr_dt_d    = '0;
            err_d      = 1'b0;
            ovf_d      = 1'b0;
            byte_cnt_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            wr_en_q      <= 1'b0;
            wr_sel_q     <= '0;
            wr_ad_q      <= '0;
            wr_dt_q      <= '0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            byte_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_ad_q      <= wr_ad_d;
            wr_dt_q      <= wr_dt_d;
            err_q        <= err_d;
            ovf_q        <= ovf_d;
            byte_cnt_q   <= byte_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

`ifdef ROMLOAD_CKSUM_EN
    logic [15:0] cksum_q, cksum_d;

    // Running sum of accepted bytes, restarted at each load.
    always_comb begin
        cksum_d = cksum_q;
        if (accept) cksum_d = cksum_q + {8'h00, ROMDT};
        if (load_entry) cksum_d = '0;
    end

    // Checksum register.
    always_ff @(posedge MCLK or negedge RST_N) begin
        if (!RST_N) cksum_q <= '0;
        else        cksum_q <= cksum_d;
    end

    assign CKSUM = cksum_q;
`else
    assign CKSUM = '0;
`endif

    assign WR_EN    = wr_en_q;
    assign WR_SEL   = wr_sel_q;
    assign WR_AD    = wr_ad_q;
    assign WR_DT    = wr_dt_q;
    assign ERR      = err_q;
    assign OVF      = ovf_q;
    assign CORE_RST = (state_q != S_RUN);
    assign DONE     = (state_q == S_RUN);

endmodule
